// File: rtl/fish_pkg.sv
// Shared fish constants, state encoding and spawn-row clamp.
// Used by the motion controller, the hit test and the sprite renderer.
package fish_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned FISH_W   = 39;
  localparam int unsigned FISH_H   = 29;

  localparam logic [11:0] TRANSPARENT_COLOR = 12'h352;

  localparam logic [9:0] V_MIN      = 10'd120;
  localparam logic [9:0] V_MAX      = 10'd440;
  localparam logic [9:0] SURFACE_V  = 10'd100;
  localparam logic [9:0] SWIM_SPEED = 10'd2;
  localparam logic [9:0] REEL_SPEED = 10'd3;
  // Fish fully off the right edge: right edge + 1 sits FISH_W past the screen.
  localparam logic [9:0] H_MAX      = 10'(SCREEN_W + FISH_W);

  localparam logic WAY_LEFT  = 1'b0;
  localparam logic WAY_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWIM   = 2'd1,
    HOOKED = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [9:0] clamp_v(input logic [9:0] v);
    if (v < V_MIN)      return V_MIN;
    else if (v > V_MAX) return V_MAX;
    else                return v;
  endfunction

endpackage

// File: rtl/fish_motion_ctrl_if.sv
// Game-logic <-> fish controller signal bundle; master is the game side,
// slave is the controller.
interface fish_motion_ctrl_if;

  logic       frame_tick;
  logic       spawn_req;
  logic [9:0] spawn_v;
  logic       spawn_dir;
  logic       hook_valid;
  logic [9:0] hook_h;
  logic [9:0] hook_v;
  logic [9:0] fish_h_position;
  logic [9:0] fish_v_position;
  logic       fish_way;
  logic       fish_appear;
  logic       busy;
  logic       caught;
  logic       escaped;

  modport master (
    output frame_tick, spawn_req, spawn_v, spawn_dir, hook_valid, hook_h, hook_v,
    input  fish_h_position, fish_v_position, fish_way, fish_appear, busy, caught, escaped
  );

  modport slave (
    input  frame_tick, spawn_req, spawn_v, spawn_dir, hook_valid, hook_h, hook_v,
    output fish_h_position, fish_v_position, fish_way, fish_appear, busy, caught, escaped
  );

endinterface

// File: rtl/fish_hit_detect.sv
// Combinational hook-vs-fish box test; box spans columns h-FISH_W..h-1
// and rows v..v+FISH_H-1.
module fish_hit_detect
  import fish_pkg::*;
(
  input  logic [9:0] h_i,
  input  logic [9:0] v_i,
  input  logic [9:0] hook_h_i,
  input  logic [9:0] hook_v_i,
  input  logic       hook_valid_i,
  output logic       hit_o
);

  logic [10:0] h_x, v_x, hook_h_x, hook_v_x;

  assign h_x      = {1'b0, h_i};
  assign v_x      = {1'b0, v_i};
  assign hook_h_x = {1'b0, hook_h_i};
  assign hook_v_x = {1'b0, hook_v_i};

  // Left bound rearranged as hook_h + FISH_W >= h so a fish near column 0 never wraps.
  assign hit_o = hook_valid_i
              && (hook_h_x + 11'(FISH_W) >= h_x)
              && (hook_h_x < h_x)
              && (v_x <= hook_v_x)
              && (hook_v_x < v_x + 11'(FISH_H));

endmodule

// File: rtl/fish_motion_ctrl.sv
// Fish spawn/swim/hook/reel controller driving the sprite renderer.
// Optional vertical wobble while swimming: define FISH_WOBBLE_EN.
module fish_motion_ctrl
  import fish_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fish_motion_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       way_q, way_d;
  logic       appear_q, appear_d;
  logic       caught_q, caught_d;
  logic       escaped_q, escaped_d;

  logic       hit_raw;
  logic       hit;
  logic [9:0] h_swim;
  logic [9:0] h_far;
  logic [9:0] v_swim;
  logic [9:0] v_reel;

  fish_hit_detect u_hit (
    .h_i          (h_q),
    .v_i          (v_q),
    .hook_h_i     (bus.hook_h),
    .hook_v_i     (bus.hook_v),
    .hook_valid_i (bus.hook_valid),
    .hit_o        (hit_raw)
  );

  assign hit = hit_raw && (state_q == SWIM);

  always_comb begin
    h_swim = h_q;
    h_far  = '0;
    if (way_q == WAY_RIGHT) begin
      h_far  = H_MAX;
      h_swim = (h_q >= H_MAX - SWIM_SPEED) ? H_MAX : h_q + SWIM_SPEED;
    end else begin
      h_swim = (h_q <= SWIM_SPEED) ? 10'd0 : h_q - SWIM_SPEED;
    end
  end

  assign v_reel = (v_q <= SURFACE_V + REEL_SPEED) ? SURFACE_V : v_q - REEL_SPEED;

`ifdef FISH_WOBBLE_EN
  logic [2:0] wob_q, wob_d;

  // Triangle: +1 on ticks 0-3, -1 on ticks 4-7.
  always_comb begin
    if (wob_q[2]) v_swim = (v_q <= V_MIN) ? V_MIN : v_q - 10'd1;
    else          v_swim = (v_q >= V_MAX + 10'd1) ? V_MAX + 10'd1 : v_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wob_q <= '0;
    else     wob_q <= wob_d;
  end
`else
  assign v_swim = v_q;
`endif

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    way_d     = way_q;
    appear_d  = appear_q;
    caught_d  = 1'b0;
    escaped_d = 1'b0;
`ifdef FISH_WOBBLE_EN
    wob_d     = wob_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.spawn_req) begin
          state_d  = SWIM;
          way_d    = bus.spawn_dir;
          v_d      = clamp_v(bus.spawn_v);
          h_d      = (bus.spawn_dir == WAY_RIGHT) ? 10'd0 : H_MAX;
          appear_d = 1'b1;
`ifdef FISH_WOBBLE_EN
          wob_d    = '0;
`endif
        end
      end
      SWIM: begin
        // A hit outranks a same-tick edge exit and freezes h.
        if (hit) begin
          state_d = HOOKED;
        end else if (bus.frame_tick) begin
          h_d = h_swim;
          v_d = v_swim;
`ifdef FISH_WOBBLE_EN
          wob_d = wob_q + 3'd1;
`endif
          if (h_swim == h_far) begin
            escaped_d = 1'b1;
            appear_d  = 1'b0;
            state_d   = DONE;
          end
        end
      end
      HOOKED: begin
        if (bus.frame_tick) begin
          v_d = v_reel;
          if (v_reel == SURFACE_V) begin
            caught_d = 1'b1;
            appear_d = 1'b0;
            state_d  = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      h_q       <= '0;
      v_q       <= '0;
      way_q     <= 1'b0;
      appear_q  <= 1'b0;
      caught_q  <= 1'b0;
      escaped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      way_q     <= way_d;
      appear_q  <= appear_d;
      caught_q  <= caught_d;
      escaped_q <= escaped_d;
    end
  end

  assign bus.fish_h_position = h_q;
  assign bus.fish_v_position = v_q;
  assign bus.fish_way        = way_q;
  assign bus.fish_appear     = appear_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.caught          = caught_q;
  assign bus.escaped         = escaped_q;

endmodule

// File: tb/tb_fish_motion_ctrl.sv
// Scenario bench for fish_motion_ctrl; caught/escaped pulses are matched
// against a queue of expected events filled by the scenarios.
module tb_fish_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic       caught;
    logic       escaped;
    logic [9:0] h;
    logic [9:0] v;
  } ev_t;

  ev_t exp_q[$];

  fish_motion_ctrl_if bus();

  fish_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: every caught/escaped cycle must match the next queued event.
  always @(negedge clk) begin
    if (bus.caught || bus.escaped) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got caught=%0b escaped=%0b h=%0d v=%0d exp no pulse",
                 bus.caught, bus.escaped, bus.fish_h_position, bus.fish_v_position);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if ({bus.caught, bus.escaped, bus.fish_h_position, bus.fish_v_position} !==
            {e.caught, e.escaped, e.h, e.v}) begin
          failures++;
          $display("FAIL pulse_event got c=%0b e=%0b h=%0d v=%0d exp c=%0b e=%0b h=%0d v=%0d",
                   bus.caught, bus.escaped, bus.fish_h_position, bus.fish_v_position,
                   e.caught, e.escaped, e.h, e.v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b0;
      step();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0;
    bus.spawn_req  = 1'b0;
    bus.spawn_v    = '0;
    bus.spawn_dir  = 1'b0;
    bus.hook_valid = 1'b0;
    bus.hook_h     = '0;
    bus.hook_v     = '0;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic spawn(input logic dir, input logic [9:0] v);
    bus.spawn_req = 1'b1;
    bus.spawn_dir = dir;
    bus.spawn_v   = v;
    step();
    bus.spawn_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.fish_way, bus.fish_appear,
         bus.busy, bus.caught, bus.escaped} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got h=%0d v=%0d way=%0b app=%0b busy=%0b exp all 0",
               bus.fish_h_position, bus.fish_v_position, bus.fish_way, bus.fish_appear, bus.busy);
    end
    $display("reset: h=%0d v=%0d busy=%0b", bus.fish_h_position, bus.fish_v_position, bus.busy);
  endtask

  task automatic test_escape_left();
    spawn(1'b0, 10'd200);
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.fish_appear, bus.busy, bus.fish_way} !==
        {10'd679, 10'd200, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL spawn_left got h=%0d v=%0d app=%0b busy=%0b way=%0b exp 679 200 1 1 0",
               bus.fish_h_position, bus.fish_v_position, bus.fish_appear, bus.busy, bus.fish_way);
    end
    ticks(339);
    checks++;
    if ({bus.fish_h_position, bus.busy, bus.fish_appear} !== {10'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL swim_left_339 got h=%0d busy=%0b app=%0b exp 1 1 1",
               bus.fish_h_position, bus.busy, bus.fish_appear);
    end
    exp_q.push_back('{caught: 1'b0, escaped: 1'b1, h: 10'd0, v: 10'd200});
    ticks(1);
    checks++;
    if ({bus.fish_h_position, bus.fish_appear, bus.busy} !== {10'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL escape_left got h=%0d app=%0b busy=%0b exp 0 0 1",
               bus.fish_h_position, bus.fish_appear, bus.busy);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL escape_idle got busy=%0b exp 0", bus.busy);
    end
    $display("escape_left: h=%0d busy=%0b", bus.fish_h_position, bus.busy);
  endtask

  task automatic test_clamp();
    spawn(1'b1, 10'd50);
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.fish_way} !== {10'd0, 10'd120, 1'b1}) begin
      failures++;
      $display("FAIL clamp_low got h=%0d v=%0d way=%0b exp 0 120 1",
               bus.fish_h_position, bus.fish_v_position, bus.fish_way);
    end
    do_reset();
    spawn(1'b1, 10'd470);
    checks++;
    if (bus.fish_v_position !== 10'd440) begin
      failures++;
      $display("FAIL clamp_high got v=%0d exp 440", bus.fish_v_position);
    end
    do_reset();
    $display("clamp: done");
  endtask

  task automatic test_hook_reel();
    spawn(1'b1, 10'd200);
    ticks(100);
    checks++;
    if (bus.fish_h_position !== 10'd200) begin
      failures++;
      $display("FAIL swim_right_100 got h=%0d exp 200", bus.fish_h_position);
    end
    bus.hook_valid = 1'b1;
    bus.hook_h     = 10'd180;
    bus.hook_v     = 10'd210;
    step();
    ticks(10);
    bus.hook_valid = 1'b0;
    ticks(23);
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.fish_appear, bus.busy} !==
        {10'd200, 10'd101, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reel_33 got h=%0d v=%0d app=%0b busy=%0b exp 200 101 1 1",
               bus.fish_h_position, bus.fish_v_position, bus.fish_appear, bus.busy);
    end
    exp_q.push_back('{caught: 1'b1, escaped: 1'b0, h: 10'd200, v: 10'd100});
    ticks(1);
    checks++;
    if ({bus.fish_v_position, bus.fish_appear, bus.busy} !== {10'd100, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reel_surface got v=%0d app=%0b busy=%0b exp 100 0 1",
               bus.fish_v_position, bus.fish_appear, bus.busy);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL caught_idle got busy=%0b exp 0", bus.busy);
    end
    $display("hook_reel: v=%0d busy=%0b", bus.fish_v_position, bus.busy);
  endtask

  task automatic test_hit_edges();
    // Hook on column h: outside the exclusive right edge, fish keeps swimming.
    spawn(1'b1, 10'd200);
    ticks(100);
    bus.hook_valid = 1'b1;
    bus.hook_h     = 10'd200;
    bus.hook_v     = 10'd210;
    step();
    ticks(1);
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position} !== {10'd202, 10'd200}) begin
      failures++;
      $display("FAIL edge_right_excl got h=%0d v=%0d exp 202 200",
               bus.fish_h_position, bus.fish_v_position);
    end
    bus.hook_valid = 1'b0;
    do_reset();
    // Inclusive left column and bottom row: hooked, h frozen, v reels.
    spawn(1'b1, 10'd200);
    ticks(100);
    bus.hook_valid = 1'b1;
    bus.hook_h     = 10'd161;
    bus.hook_v     = 10'd228;
    step();
    ticks(1);
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.busy} !== {10'd200, 10'd197, 1'b1}) begin
      failures++;
      $display("FAIL edge_left_bottom got h=%0d v=%0d busy=%0b exp 200 197 1",
               bus.fish_h_position, bus.fish_v_position, bus.busy);
    end
    $display("hit_edges: h=%0d v=%0d", bus.fish_h_position, bus.fish_v_position);
  endtask

  task automatic test_reset_mid_hooked();
    rst = 1'b1;
    step();
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.fish_way, bus.fish_appear,
         bus.busy, bus.caught, bus.escaped} !== 25'd0) begin
      failures++;
      $display("FAIL reset_hooked got h=%0d v=%0d way=%0b app=%0b busy=%0b exp all 0",
               bus.fish_h_position, bus.fish_v_position, bus.fish_way, bus.fish_appear, bus.busy);
    end
    do_reset();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hooked_idle got busy=%0b exp 0", bus.busy);
    end
    $display("reset_mid_hooked: busy=%0b", bus.busy);
  endtask

  task automatic test_spawn_ignored();
    bus.spawn_req = 1'b1;
    bus.spawn_dir = 1'b0;
    bus.spawn_v   = 10'd300;
    step();
    bus.spawn_dir = 1'b1;
    bus.spawn_v   = 10'd150;
    ticks(5);
    checks++;
    if ({bus.fish_h_position, bus.fish_v_position, bus.fish_way} !== {10'd669, 10'd300, 1'b0}) begin
      failures++;
      $display("FAIL spawn_ignored got h=%0d v=%0d way=%0b exp 669 300 0",
               bus.fish_h_position, bus.fish_v_position, bus.fish_way);
    end
    bus.spawn_req = 1'b0;
    do_reset();
    $display("spawn_ignored: done");
  endtask

  initial begin
    test_reset();
    test_escape_left();
    test_clamp();
    test_hook_reel();
    test_hit_edges();
    test_reset_mid_hooked();
    test_spawn_ignored();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
